// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared state encoding and default sizing for serial_adder
package serial_adder_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_DIGIT = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/serial_adder_digit_adder.sv
// rtl/serial_adder_digit_adder.sv - combinational DIGIT-bit slice adder with carry into its MSB
module digit_adder #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a_i,
    input  logic [DIGIT-1:0] b_i,
    input  logic             c_i,
    output logic [DIGIT-1:0] s_o,
    output logic             c_o,
    output logic             c_msb_o
);

    logic [DIGIT:0] full;

    assign full = {1'b0, a_i} + {1'b0, b_i} + {{DIGIT{1'b0}}, c_i};
    assign s_o  = full[DIGIT-1:0];
    assign c_o  = full[DIGIT];
    // The MSB sum bit is a ^ b ^ carry-in, so the carry into it falls out by xor.
    assign c_msb_o = full[DIGIT-1] ^ a_i[DIGIT-1] ^ b_i[DIGIT-1];

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - digit-serial add/subtract unit; SERIAL_ADDER_SUB_EN enables the sub input
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DIGIT = DEF_DIGIT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int STEPS = WIDTH / DIGIT;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

    state_e           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;
    logic             busy_q;
    logic             done_q;
    logic             cout_q;
    logic             ovf_q;

    logic             sub_eff;
    logic [DIGIT-1:0] dig_s;
    logic             dig_c;
    logic             dig_cmsb;
    logic [WIDTH-1:0] acc_d;
    logic             last_step;

`ifdef SERIAL_ADDER_SUB_EN
    assign sub_eff = sub;
`else
    // Subtraction compiled out: the port stays for pin compatibility but never takes effect.
    assign sub_eff = 1'b0 & sub;
`endif

    digit_adder #(.DIGIT(DIGIT)) u_digit (
        .a_i     (a_q[DIGIT-1:0]),
        .b_i     (b_q[DIGIT-1:0]),
        .c_i     (carry_q),
        .s_o     (dig_s),
        .c_o     (dig_c),
        .c_msb_o (dig_cmsb)
    );

    // Slice results enter at the top and walk down, so after STEPS cycles acc holds the full sum.
    assign acc_d     = WIDTH'({dig_s, acc_q} >> DIGIT);
    assign last_step = (cnt_q == CW'(STEPS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b ^ {WIDTH{sub_eff}};
                        carry_q <= cin ^ sub_eff;
                        cnt_q   <= '0;
                        state_q <= ST_BUSY;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                ST_BUSY: begin
                    a_q     <= a_q >> DIGIT;
                    b_q     <= b_q >> DIGIT;
                    acc_q   <= acc_d;
                    carry_q <= dig_c;
                    cnt_q   <= cnt_q + CW'(1);
                    if (last_step) begin
                        sum_q   <= acc_d;
                        cout_q  <= dig_c;
                        ovf_q   <= dig_c ^ dig_cmsb;
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule
